// File: rtl/mem_output_pkg.sv
// mem_output_pkg: shared sizing constants and capture FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// The sizing constants are common with the stimulus memory, so both ends of
// the datapath agree on word width and depth.
package mem_output_pkg;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_LOG2_DEPTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/mem_output_if.sv
// mem_output_if: capture-input, readback and status bundle for mem_output.
// Latency: n/a (wiring only).
// Backpressure: none; the sink never stalls the producer, excess words are dropped.
// Ports: master drives start/num_of_dat/dat_in/dat_in_vld/rd_en/rd_addr;
//        slave (mem_output) drives rd_dat/rd_vld/captured_cnt/busy/done/overflow.
// Optional: MEM_OUTPUT_CHKSUM_EN adds the slave-driven chksum signal.
interface mem_output_if
  import mem_output_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int log2_DEPTH = DEF_LOG2_DEPTH
);

  logic                  start;
  logic [log2_DEPTH-1:0] num_of_dat;
  logic [WIDTH-1:0]      dat_in;
  logic                  dat_in_vld;
  logic                  rd_en;
  logic [log2_DEPTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_dat;
  logic                  rd_vld;
  logic [log2_DEPTH:0]   captured_cnt;
  logic                  busy;
  logic                  done;
  logic                  overflow;
`ifdef MEM_OUTPUT_CHKSUM_EN
  logic [WIDTH-1:0]      chksum;
`endif

  modport master (
    output start, num_of_dat, dat_in, dat_in_vld, rd_en, rd_addr,
    input  rd_dat, rd_vld, captured_cnt, busy, done, overflow
`ifdef MEM_OUTPUT_CHKSUM_EN
    , input chksum
`endif
  );

  modport slave (
    input  start, num_of_dat, dat_in, dat_in_vld, rd_en, rd_addr,
    output rd_dat, rd_vld, captured_cnt, busy, done, overflow
`ifdef MEM_OUTPUT_CHKSUM_EN
    , output chksum
`endif
  );

endinterface

// File: rtl/mem_output_ram.sv
// mem_output_ram: simple dual-port word array, one sync write port, one registered read port.
// Latency: write lands on the sampling edge; read data appears 1 cycle after rd_en.
// Backpressure: none; every request is serviced in its cycle.
// Ports: clk, rst_n (resets only the read register), wr_en/wr_addr/wr_dat, rd_en/rd_addr/rd_dat.
// Reads of an address written in the same cycle return the old contents.
// Read addresses beyond DEPTH return zero rather than aliasing onto stored words.
module mem_output_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int log2_DEPTH = 6,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic                  rd_en,
  input  logic [log2_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  localparam logic [log2_DEPTH:0] DEPTH_W = (log2_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_in_range;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // Storage is deliberately not reset: contents survive reset and restart.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= rd_in_range ? mem[rd_addr[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/mem_output.sv
// mem_output: sink-side capture memory; stores num_of_dat+1 valid words after start, then pulses done.
// Latency: word stored on its sampling edge, count/done visible next cycle; readback 1 cycle.
// Backpressure: none; words arriving outside a capture (or past DEPTH) are dropped and flag overflow.
// Ports: clk, rst_n (async active-low), bus (mem_output_if.slave).
// Optional: MEM_OUTPUT_CHKSUM_EN adds bus.chksum, a running XOR of stored words.
module mem_output
  import mem_output_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int log2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_output_if.slave  bus
);

  localparam int                  AW      = $clog2(DEPTH);
  localparam logic [log2_DEPTH:0] DEPTH_W = (log2_DEPTH+1)'(DEPTH);

  state_t                state, state_nxt;
  logic [log2_DEPTH-1:0] len_q;
  logic [log2_DEPTH-1:0] wr_ptr;
  logic [log2_DEPTH:0]   cnt_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  rd_vld_q;

  logic accept;  // valid word consumed by the capture sequence
  logic store;   // consumed word that also fits in the array
  logic last;    // consumed word is the final one of this capture
  logic drop;    // valid word that does not reach the array

  // wr_ptr keeps advancing past DEPTH so that done still tracks num_of_dat+1
  // words even when the programmed length exceeds the array.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    store     = 1'b0;
    last      = 1'b0;
    drop      = 1'b0;

    accept = (state == ST_CAPTURE) && bus.dat_in_vld && !bus.start;
    store  = accept && ({1'b0, wr_ptr} < DEPTH_W);
    last   = accept && (wr_ptr == len_q);
    drop   = bus.dat_in_vld && !store;

    case (state)
      ST_IDLE:    if (bus.start) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (bus.start)  state_nxt = ST_CAPTURE;
        else if (last)  state_nxt = ST_DONE;
      end
      ST_DONE:    if (bus.start) state_nxt = ST_CAPTURE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      wr_ptr   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= bus.rd_en;
      done_q   <= last;
      if (bus.start) begin
        len_q  <= bus.num_of_dat;
        wr_ptr <= '0;
        cnt_q  <= '0;
        // A word colliding with start is itself a drop, so it re-flags
        // overflow in the same edge that clears the previous one.
        ovf_q  <= drop;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (store)  cnt_q  <= cnt_q + 1'b1;
        if (drop)   ovf_q  <= 1'b1;
      end
    end
  end

`ifdef MEM_OUTPUT_CHKSUM_EN
  logic [WIDTH-1:0] chk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (bus.start) begin
      chk_q <= '0;
    end else if (store) begin
      chk_q <= chk_q ^ bus.dat_in;
    end
  end

  assign bus.chksum = chk_q;
`endif

  mem_output_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .log2_DEPTH (log2_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (store),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  (bus.dat_in),
    .rd_en   (bus.rd_en),
    .rd_addr (bus.rd_addr),
    .rd_dat  (bus.rd_dat)
  );

  assign bus.rd_vld       = rd_vld_q;
  assign bus.captured_cnt = cnt_q;
  assign bus.busy         = (state == ST_CAPTURE);
  assign bus.done         = done_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: doc/mem_output.md
# mem_output

Capture memory at the sink end of the simulation stimulus path. Armed by `start`, it writes each valid word from the unit under test into an internal array in arrival order, counts words until the programmed `num_of_dat` is reached, and then pulses `done`. After capture, the bench reads stored results back through a one-cycle-latency read port. Word width and depth match the stimulus memory so both ends of the datapath share one sizing.

## Interface
- `WIDTH`, 64, data word width
- `DEPTH`, 32, number of storage words
- `log2_DEPTH`, 6, width of counters, addresses and `num_of_dat`
- `clk`  in  1  single clock; all logic samples on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  one-cycle pulse; arms (or re-arms) capture
- `num_of_dat`  in  log2_DEPTH  index of the last word; capture length is num_of_dat+1 words; sampled at `start`
- `dat_in`  in  WIDTH  result word
- `dat_in_vld`  in  1  `dat_in` is valid this cycle
- `rd_en`  in  1  readback request
- `rd_addr`  in  log2_DEPTH  readback word index
- `rd_dat`  out  WIDTH  readback data
- `rd_vld`  out  1  `rd_dat` is valid
- `captured_cnt`  out  log2_DEPTH+1  number of words stored since the last `start`
- `busy`  out  1  high while in the CAPTURE state
- `done`  out  1  one-cycle pulse when capture completes
- `overflow`  out  1  sticky; set when a word is dropped

## Operation
- The state machine has three states: IDLE, CAPTURE and DONE. Reset enters IDLE.
- IDLE→CAPTURE on `start`. DONE→CAPTURE on `start`. CAPTURE→CAPTURE on `start`, which restarts the capture.
- On any `start`, the block latches `num_of_dat` into `len_q`, clears the write pointer and `captured_cnt`, and clears `overflow`.
- In CAPTURE, each cycle with `dat_in_vld` high:
  - writes `mem[wr_ptr]`,
  - increments `wr_ptr` and `captured_cnt`,
  - moves CAPTURE→DONE if `wr_ptr==len_q`. This means exactly len_q+1 words are stored.
- A word is dropped and `overflow` is set if `dat_in_vld` is high in any of these cases:
  - in IDLE or DONE,
  - in CAPTURE with `wr_ptr>=DEPTH` (only reachable when len_q≥DEPTH),
  - in the same cycle as `start`. `start` has priority; the word is neither stored nor counted.
- Memory is not cleared by reset or by `start`. Unwritten locations read back as undefined (X in simulation).
- The read port is independent of state. Reading an address while it is being written in the same cycle returns the old contents.
- Reset mid-capture returns the block to IDLE and clears all outputs. Memory contents are retained.

## Timing
- Reset values: `rd_dat`=0, `rd_vld`=0, `captured_cnt`=0, `busy`=0, `done`=0, `overflow`=0. Checksum is 0 when enabled.
- `busy` is registered. It goes high the cycle after `start` and low the cycle after the last write.
- `done` is high for exactly one cycle, the cycle after the edge that stores the last word. It coincides with the first cycle of DONE.
- Write latency: a word is stored on the edge where `dat_in_vld` is sampled. `captured_cnt` reflects that word in the next cycle.
- Read latency: 1 cycle. `rd_en` at edge n produces `rd_dat`/`rd_vld` after edge n. `rd_vld` is a copy of `rd_en` delayed by one cycle. `rd_dat` holds its value when `rd_en` is low.
- Back-to-back valid words at full rate (one per cycle) are supported.
- `overflow` sets on the edge after the offending word and holds until the next `start` or reset.

## Configuration
- Macro: `MEM_OUTPUT_CHKSUM_EN`.
- When defined, the block adds the output `chksum` [WIDTH-1:0]. It is a running XOR of every stored word, cleared by `start`, and updated together with `captured_cnt`.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- The shared package holds the state enum (`ST_IDLE`, `ST_CAPTURE`, `ST_DONE`) and the default `WIDTH`/`DEPTH`/`log2_DEPTH` constants, which are common with the stimulus memory.
- One sub-module, `mem_output_ram`: a simple dual-port array with one synchronous write port and one registered read port. It holds no control logic.

## Test plan
- Basic capture: `start` with `num_of_dat`=3, then 4 consecutive valid words 0xA0..0xA3 → `done` pulses once, the cycle after 0xA3; `captured_cnt`=4; reading addresses 0..3 returns 0xA0..0xA3 with 1-cycle latency; `overflow`=0.
- Gapped input: `num_of_dat`=2, valid words with 2 idle cycles between each → `busy` stays high throughout; `done` follows the third word; stored words are correct.
- Overflow: after `done`, drive one more valid word 0xFF → `overflow`=1 the next cycle; `captured_cnt` stays unchanged; address 3 is not overwritten. `num_of_dat`=40 with 41 words → 32 stored, `overflow`=1, `done` after word 41.
- Restart: `start` mid-capture after 2 words, then `num_of_dat`=1 and words 0xB0, 0xB1 → `captured_cnt`=2; address 0 = 0xB0; `overflow` cleared.
- Collision: `start` and `dat_in_vld` in the same cycle → the word is not stored and `captured_cnt`=0 the next cycle. Deassert `rst_n` mid-capture → all outputs return to 0 asynchronously and the block is in IDLE.
- With `MEM_OUTPUT_CHKSUM_EN`: words 0x0F, 0xF0, 0x11 → `chksum`=0xEE; `start` clears it to 0.
